// File: rtl/sauria_demo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sauria_demo_pkg
// Description : Shared constants and types for the AXI4-Lite to register
//               interface responder: AXI response codes, FSM state encoding
//               and the default register-side wait limit.
// Revision    : 1.0 - initial release
// ============================================================================
package sauria_demo_pkg;

  // AXI response codes
  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespSlvErr = 2'b10;

  // Default register-side wait limit (only used when the timeout is built in)
  localparam int unsigned DefaultTimeoutCycles = 256;

  // FSM state encodings (kept as plain constants for legacy users)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR_REQ = 3'd1;
  localparam logic [2:0] ST_WR_RSP = 3'd2;
  localparam logic [2:0] ST_RD_REQ = 3'd3;
  localparam logic [2:0] ST_RD_RSP = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = ST_IDLE,
    StWrReq = ST_WR_REQ,
    StWrRsp = ST_WR_RSP,
    StRdReq = ST_RD_REQ,
    StRdRsp = ST_RD_RSP
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sauria_axil_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : sauria_axil_reg_responder
// Description : AXI4-Lite slave that turns each accepted read or write into a
//               single register-interface request. One transaction in flight,
//               reads and writes arbitrated round-robin.
//               Optional register-side timeout: SAURIA_AXIL_REG_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sauria_axil_reg_responder
  import sauria_demo_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   axil_aw_addr_i,
  input  logic                   axil_aw_valid_i,
  output logic                   axil_aw_ready_o,
  input  logic [DataWidth-1:0]   axil_w_data_i,
  input  logic [DataWidth/8-1:0] axil_w_strb_i,
  input  logic                   axil_w_valid_i,
  output logic                   axil_w_ready_o,
  output logic [1:0]             axil_b_resp_o,
  output logic                   axil_b_valid_o,
  input  logic                   axil_b_ready_i,
  input  logic [AddrWidth-1:0]   axil_ar_addr_i,
  input  logic                   axil_ar_valid_i,
  output logic                   axil_ar_ready_o,
  output logic [DataWidth-1:0]   axil_r_data_o,
  output logic [1:0]             axil_r_resp_o,
  output logic                   axil_r_valid_o,
  input  logic                   axil_r_ready_i,
  output logic [AddrWidth-1:0]   reg_addr_o,
  output logic                   reg_write_o,
  output logic [DataWidth-1:0]   reg_wdata_o,
  output logic [DataWidth/8-1:0] reg_wstrb_o,
  output logic                   reg_valid_o,
  input  logic [DataWidth-1:0]   reg_rdata_i,
  input  logic                   reg_error_i,
  input  logic                   reg_ready_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  // Reject unsupported configurations at elaboration
  if (!((DataWidth == 32) || (DataWidth == 64)) || (TimeoutCycles < 2)) begin : g_param_check
    $error("sauria_axil_reg_responder: DataWidth must be 32/64 and TimeoutCycles >= 2");
  end

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_last_wr;   // 1: last grant was a write, so reads win a tie
  logic [AddrWidth-1:0]   r_addr;
  logic [DataWidth-1:0]   r_wdata;
  logic [StrbWidth-1:0]   r_wstrb;
  logic [1:0]             r_resp;
  logic [DataWidth-1:0]   r_rdata;

  logic w_wr_elig;
  logic w_rd_elig;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_in_req;
  logic w_timeout;
  logic w_done;
  logic w_err;

  // A write needs AW and W together; a lone channel is never accepted
  assign w_wr_elig  = axil_aw_valid_i && axil_w_valid_i;
  assign w_rd_elig  = axil_ar_valid_i;
  assign w_grant_wr = (r_state == StIdle) && w_wr_elig && (!w_rd_elig || !r_last_wr);
  assign w_grant_rd = (r_state == StIdle) && w_rd_elig && (!w_wr_elig || r_last_wr);

  assign w_in_req = (r_state == StWrReq) || (r_state == StRdReq);
  assign w_done   = w_in_req && (reg_ready_i || w_timeout);
  // A timeout completes without ready and is always reported as an error
  assign w_err    = !reg_ready_i || reg_error_i;

`ifdef SAURIA_AXIL_REG_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles) + 1;
  logic [CntWidth-1:0] r_cnt;

  assign w_timeout = w_in_req && !reg_ready_i &&
                     (r_cnt == CntWidth'(TimeoutCycles - 1));

  // Count stalled request cycles; restart on every new grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (w_grant_wr || w_grant_rd) begin
      r_cnt <= '0;
    end else if (w_in_req && !reg_ready_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant_wr)      w_state_nxt = StWrReq;
        else if (w_grant_rd) w_state_nxt = StRdReq;
      end
      StWrReq: if (w_done) w_state_nxt = StWrRsp;
      StRdReq: if (w_done) w_state_nxt = StRdRsp;
      StWrRsp: if (axil_b_ready_i) w_state_nxt = StIdle;
      StRdRsp: if (axil_r_ready_i) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_last_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_wr)      r_last_wr <= 1'b1;
      else if (w_grant_rd) r_last_wr <= 1'b0;
    end
  end

  // Latch the request on grant and the response on register completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_resp  <= AxiRespOkay;
      r_rdata <= '0;
    end else begin
      if (w_grant_wr) begin
        r_addr  <= axil_aw_addr_i;
        r_wdata <= axil_w_data_i;
        r_wstrb <= axil_w_strb_i;
      end else if (w_grant_rd) begin
        r_addr  <= axil_ar_addr_i;
      end
      if (w_done) begin
        r_resp <= w_err ? AxiRespSlvErr : AxiRespOkay;
        if (r_state == StRdReq) begin
          r_rdata <= w_err ? '0 : reg_rdata_i;
        end
      end
    end
  end

  assign axil_aw_ready_o = w_grant_wr;
  assign axil_w_ready_o  = w_grant_wr;
  assign axil_ar_ready_o = w_grant_rd;
  assign axil_b_valid_o  = (r_state == StWrRsp);
  assign axil_b_resp_o   = r_resp;
  assign axil_r_valid_o  = (r_state == StRdRsp);
  assign axil_r_resp_o   = r_resp;
  assign axil_r_data_o   = r_rdata;

  assign reg_valid_o = w_in_req;
  assign reg_write_o = (r_state == StWrReq);
  assign reg_addr_o  = r_addr;
  assign reg_wdata_o = r_wdata;
  assign reg_wstrb_o = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_sauria_axil_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sauria_axil_reg_responder
// Description : Self-checking bench for sauria_axil_reg_responder: directed
//               vector table, arbitration / lone-AW / reset sequences, timeout
//               (or long wait) case and randomized single transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sauria_axil_reg_responder;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] aw_addr, w_data, ar_addr, reg_rdata;
  logic [3:0]  w_strb;
  logic        aw_valid, w_valid, ar_valid, b_ready, r_ready, reg_error, reg_ready;

  logic        aw_ready, w_ready, ar_ready, b_valid, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data, reg_addr, reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_write, reg_valid;

  int   total = 0;
  int   bad   = 0;
  logic last_wr = 1'b0;   // model: last granted type was a write

  sauria_axil_reg_responder #(
    .AddrWidth(32), .DataWidth(32), .TimeoutCycles(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axil_aw_addr_i(aw_addr), .axil_aw_valid_i(aw_valid), .axil_aw_ready_o(aw_ready),
    .axil_w_data_i(w_data), .axil_w_strb_i(w_strb), .axil_w_valid_i(w_valid),
    .axil_w_ready_o(w_ready),
    .axil_b_resp_o(b_resp), .axil_b_valid_o(b_valid), .axil_b_ready_i(b_ready),
    .axil_ar_addr_i(ar_addr), .axil_ar_valid_i(ar_valid), .axil_ar_ready_o(ar_ready),
    .axil_r_data_o(r_data), .axil_r_resp_o(r_resp), .axil_r_valid_o(r_valid),
    .axil_r_ready_i(r_ready),
    .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata),
    .reg_wstrb_o(reg_wstrb), .reg_valid_o(reg_valid), .reg_rdata_i(reg_rdata),
    .reg_error_i(reg_error), .reg_ready_i(reg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          wait_c;
    logic        err;
    logic [31:0] rdata;
    int          rsp_delay;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Round-robin model: on a tie the type not granted last time wins
  function automatic logic model_pick_wr(input logic wr_elig, input logic rd_elig);
    return wr_elig && (!rd_elig || !last_wr);
  endfunction

  // Present one request and complete its AXI address handshake
  task automatic issue(input logic is_wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    int n;
    n = 0;
    if (is_wr) begin
      aw_addr = addr; w_data = data; w_strb = strb; aw_valid = 1'b1; w_valid = 1'b1;
    end else begin
      ar_addr = addr; ar_valid = 1'b1;
    end
    #1;
    while (!(is_wr ? (aw_ready && w_ready) : ar_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("grant", is_wr ? (aw_ready && w_ready) : ar_ready, 1'b1);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
  endtask

  // Called at posedge+1 right after the handshake edge: act as the register
  // peripheral, then as the AXI master collecting the response
  task automatic serve(input logic is_wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int wait_c, input logic err,
                       input logic [31:0] rdata, input int rsp_delay,
                       input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                       input int exp_cycles);
    int          n;
    logic        field_bad, hold_bad;
    logic [1:0]  resp0;
    logic [31:0] data0;
    last_wr   = is_wr;
    n         = 0;
    field_bad = 1'b0;
    reg_error = err;
    reg_rdata = rdata;
    while (reg_valid === 1'b1 && n < 300) begin
      if (reg_write !== is_wr || reg_addr !== addr) field_bad = 1'b1;
      if (is_wr && (reg_wdata !== data || reg_wstrb !== strb)) field_bad = 1'b1;
      if (aw_ready || w_ready || ar_ready || b_valid || r_valid) field_bad = 1'b1;
      reg_ready = (n == wait_c);
      @(posedge clk); #1; n++;
    end
    reg_ready = 1'b0; reg_error = 1'b0; reg_rdata = '0;
    chk("reg_fields", field_bad, 1'b0);
    chk("reg_cycles", n, exp_cycles);
    chk("rsp_valid", is_wr ? b_valid : r_valid, 1'b1);
    chk("rsp_resp", is_wr ? b_resp : r_resp, exp_resp);
    if (!is_wr) chk("rd_data", r_data, exp_rdata);
    resp0    = is_wr ? b_resp : r_resp;
    data0    = r_data;
    hold_bad = 1'b0;
    for (int i = 0; i < rsp_delay; i++) begin
      @(posedge clk); #1;
      if ((is_wr ? b_valid : r_valid) !== 1'b1 || (is_wr ? b_resp : r_resp) !== resp0) hold_bad = 1'b1;
      if (!is_wr && r_data !== data0) hold_bad = 1'b1;
      if (reg_valid || aw_ready || ar_ready) hold_bad = 1'b1;
    end
    chk("rsp_hold", hold_bad, 1'b0);
    if (is_wr) b_ready = 1'b1; else r_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0; r_ready = 1'b0;
    chk("rsp_done", is_wr ? b_valid : r_valid, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    logic        exp_wr, lone_bad, is_wr, err;
    logic [31:0] addr, data, rdata;
    logic [3:0]  strb;
    int          wait_c, rsp_delay;

    vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0,         0, 2'b00, 32'h0,         1};
    vecs[1] = '{1'b0, 32'h0000_2004, 32'h0,         4'h0, 3, 1'b0, 32'h1234_5678, 0, 2'b00, 32'h1234_5678, 4};
    vecs[2] = '{1'b0, 32'h0000_2008, 32'h0,         4'h0, 0, 1'b1, 32'hAAAA_5555, 2, 2'b10, 32'h0,         1};
    vecs[3] = '{1'b1, 32'h0000_1003, 32'h0102_0304, 4'h0, 1, 1'b0, 32'h0,         5, 2'b00, 32'h0,         2};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h5A5A_A5A5, 4'h5, 2, 1'b1, 32'h0,         1, 2'b10, 32'h0,         3};
    vecs[5] = '{1'b0, 32'h0000_0001, 32'h0,         4'h0, 0, 1'b0, 32'hFFFF_FFFF, 1, 2'b00, 32'hFFFF_FFFF, 1};

    rst_n = 1'b0;
    aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0; reg_rdata = '0;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
    reg_error = 1'b0; reg_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {aw_ready, w_ready, ar_ready, b_valid, r_valid, reg_valid, reg_write, b_resp, r_resp}, '0);
    chk("reset_rdata", r_data, '0);
    chk("reset_reg", {reg_addr, reg_wdata, reg_wstrb}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].is_wr, vecs[v].addr, vecs[v].data, vecs[v].strb);
      serve(vecs[v].is_wr, vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].wait_c,
            vecs[v].err, vecs[v].rdata, vecs[v].rsp_delay, vecs[v].exp_resp,
            vecs[v].exp_rdata, vecs[v].exp_cycles);
    end

    // All three channels valid, three grants in a row: write, read, write
    ar_addr = 32'h0000_3000; ar_valid = 1'b1;
    aw_addr = 32'h0000_3100; w_data = 32'hCAFE_0001; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_wr = model_pick_wr(1'b1, 1'b1);
      chk("arb_aw_ready", {aw_ready, w_ready}, {exp_wr, exp_wr});
      chk("arb_ar_ready", ar_ready, !exp_wr);
      @(posedge clk); #1;
      if (exp_wr) begin
        aw_valid = 1'b0; w_valid = 1'b0;
        serve(1'b1, 32'h0000_3100, 32'hCAFE_0001, 4'hF, 0, 1'b0, 32'h0, 0, 2'b00, 32'h0, 1);
        aw_valid = 1'b1; w_valid = 1'b1;
      end else begin
        ar_valid = 1'b0;
        serve(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 0, 2'b00, 32'h0BAD_F00D, 2);
        ar_valid = 1'b1;
      end
      #1;
    end
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;

    // Lone AW for 10 cycles, then W joins
    aw_addr = 32'h0000_4000; aw_valid = 1'b1; lone_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (aw_ready || w_ready || reg_valid) lone_bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("lone_aw_blocked", lone_bad, 1'b0);
    w_data = 32'h7777_8888; w_strb = 4'h3; w_valid = 1'b1;
    #1;
    chk("aw_w_together", {aw_ready, w_ready}, 2'b11);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
    serve(1'b1, 32'h0000_4000, 32'h7777_8888, 4'h3, 0, 1'b0, 32'h0, 0, 2'b00, 32'h0, 1);

    // Reset asserted while a read waits on the register side
    ar_addr = 32'h0000_5000; ar_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_req_valid", reg_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {reg_valid, reg_write, r_valid, b_valid, ar_ready}, '0);
    chk("rst_async_addr", reg_addr, '0);
    @(negedge clk); rst_n = 1'b1; last_wr = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 32'h0000_5008, 32'h0, 4'h0);
    serve(1'b0, 32'h0000_5008, 32'h0, 4'h0, 1, 1'b0, 32'h1357_9BDF, 0, 2'b00, 32'h1357_9BDF, 2);

    // Register side never ready within the timeout window (or long wait)
`ifdef SAURIA_AXIL_REG_TIMEOUT_EN
    issue(1'b0, 32'h0000_6000, 32'h0, 4'h0);
    serve(1'b0, 32'h0000_6000, 32'h0, 4'h0, 100, 1'b0, 32'h2468_ACE0, 0, 2'b10, 32'h0, TMO);
`else
    issue(1'b0, 32'h0000_6000, 32'h0, 4'h0);
    serve(1'b0, 32'h0000_6000, 32'h0, 4'h0, 30, 1'b0, 32'h2468_ACE0, 0, 2'b00, 32'h2468_ACE0, 31);
`endif

    // Randomized single transactions against the response model
    for (int t = 0; t < 30; t++) begin
      is_wr     = 1'($urandom_range(0, 1));
      addr      = $urandom;
      data      = $urandom;
      strb      = 4'($urandom_range(0, 15));
      wait_c    = $urandom_range(0, 6);
      err       = ($urandom_range(0, 3) == 0);
      rdata     = $urandom;
      rsp_delay = $urandom_range(0, 3);
      issue(is_wr, addr, data, strb);
      serve(is_wr, addr, data, strb, wait_c, err, rdata, rsp_delay,
            err ? 2'b10 : 2'b00, err ? 32'h0 : rdata, wait_c + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sauria_axil_reg_responder.md
Name: sauria_axil_reg_responder

Overview:
- AXI4-Lite slave (responder) that terminates an AXI4-Lite configuration master and issues single transactions on a register-interface master port.
- It is the reverse of the register-to-AXI4-Lite path that drives SAURIA's configuration port.
- Use: lets SAURIA-side or external AXI4-Lite initiators reach Cheshire register-interface peripherals.
- One transaction outstanding at a time; reads and writes are arbitrated round-robin.

Parameters:
- AddrWidth, 32, AXI4-Lite and register address width.
- DataWidth, 32, data width; must be 32 or 64.
- TimeoutCycles, 256, register-side wait limit. Used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- axil_aw_addr_i  in  AddrWidth  write address
- axil_aw_valid_i / axil_aw_ready_o  in/out  1  AW handshake
- axil_w_data_i  in  DataWidth  write data
- axil_w_strb_i  in  DataWidth/8  write strobes
- axil_w_valid_i / axil_w_ready_o  in/out  1  W handshake
- axil_b_resp_o  out  2  write response
- axil_b_valid_o / axil_b_ready_i  out/in  1  B handshake
- axil_ar_addr_i  in  AddrWidth  read address
- axil_ar_valid_i / axil_ar_ready_o  in/out  1  AR handshake
- axil_r_data_o  out  DataWidth  read data
- axil_r_resp_o  out  2  read response
- axil_r_valid_o / axil_r_ready_i  out/in  1  R handshake
- reg_addr_o  out  AddrWidth  register address
- reg_write_o  out  1  1 = write
- reg_wdata_o  out  DataWidth  register write data
- reg_wstrb_o  out  DataWidth/8  register strobes
- reg_valid_o  out  1  request valid
- reg_rdata_i  in  DataWidth  register read data
- reg_error_i  in  1  register error
- reg_ready_i  in  1  request accepted/completed

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - All ready and valid outputs 0.
  - b_resp, r_resp, r_data 0.
  - reg_* outputs 0.
  - FSM in IDLE; round-robin pointer prefers write.
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP.
- IDLE:
  - A write is eligible only when aw_valid and w_valid are both 1. AW and W are accepted in the same cycle; a lone AW or lone W is never accepted.
  - A read is eligible when ar_valid is 1.
  - If both are eligible, grant the opposite of the last granted type. The pointer updates on grant.
  - Ready outputs are combinational in IDLE: aw_ready = w_ready = grant_wr; ar_ready = grant_rd. They are 0 in all other states.
  - On grant, latch addr, data and strb into request registers, then go to WR_REQ or RD_REQ.
- WR_REQ / RD_REQ:
  - reg_valid_o = 1; reg_write_o = 1 for WR_REQ, 0 for RD_REQ; address, data and strobes are held stable.
  - When reg_ready_i = 1 in the same cycle:
    - Capture reg_error_i: resp = 2'b10 (SLVERR) if 1, else 2'b00 (OKAY).
    - RD_REQ also captures reg_rdata_i.
    - Drop reg_valid_o next cycle and go to WR_RSP or RD_RSP.
  - Minimum latency: AR/AW handshake to R/B valid = 2 cycles when reg_ready_i is already 1.
- WR_RSP / RD_RSP:
  - b_valid or r_valid is held with stable resp and data until the ready input is 1, then return to IDLE.
  - A new grant may occur in the cycle after returning to IDLE, not in the cycle of the response handshake.
- Read data with error: r_data = 0 when reg_error_i = 1.
- Address passthrough: unaligned addresses are passed unmodified; alignment is the peripheral's concern.
- w_strb = 0 is forwarded as-is, with no special case.
- Reset mid-operation: the FSM returns to IDLE immediately and the in-flight transaction is dropped. reg_valid_o deasserts asynchronously with reset.

Optional Feature:
- Macro: SAURIA_AXIL_REG_TIMEOUT_EN.
- With the macro:
  - A counter is cleared on entry to WR_REQ or RD_REQ and increments each cycle while reg_ready_i = 0.
  - On reaching TimeoutCycles-1 without ready, reg_valid_o deasserts and the response is SLVERR (read data 0). The FSM goes to the response state.
  - A late reg_ready_i is ignored.
  - Counter width is $clog2(TimeoutCycles)+1.
- Without the macro: no counter, and the block waits indefinitely for reg_ready_i.

Decomposition:
- sauria_demo_pkg holds:
  - AXI response constants (AxiRespOkay = 2'b00, AxiRespSlvErr = 2'b10).
  - The FSM state enum typedef.
  - The default TimeoutCycles constant.
- No sub-module. The round-robin pointer and timeout counter are small enough to stay inline.

Test Plan:
- Write 0x1000 with data 0xDEADBEEF, strb 0xF, reg_ready_i = 1 immediately -> one reg_valid cycle with write = 1 and matching fields; B valid 2 cycles after AW; resp 2'b00.
- Read 0x2004 with reg_rdata_i = 0x12345678 and ready after 3 wait cycles -> r_data = 0x12345678, resp 2'b00; reg_valid held 4 cycles with address stable.
- AW/W and AR all valid in the same cycle, twice in succession -> write granted first, then read, then write: the grant alternates.
- Read with reg_error_i = 1 -> r_resp = 2'b10, r_data = 0. Write with r_ready/b_ready low for 5 cycles -> response held stable, no new reg_valid.
- AW valid without W for 10 cycles -> aw_ready stays 0 and no register request is issued. W arriving later -> both accepted together.
- Reset asserted during RD_REQ -> all outputs 0 asynchronously; a read issued after reset completes normally. With SAURIA_AXIL_REG_TIMEOUT_EN, TimeoutCycles = 16 and reg_ready_i tied 0 -> SLVERR after 16 cycles.
